// File: rtl/ksa4_ctrl_pkg.sv
// Shared types and constants for the sliced KSA4 sequencer.
package ksa4_ctrl_pkg;

    localparam int SLICE_W   = 4;
    // Wide enough for ADDER_LAT up to 15
    localparam int LAT_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Width of the slice index; at least one bit even for a single slice
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ksa4_seq_if.sv
// Operand/result handshake bundle of the KSA4 sequencer.
interface ksa4_seq_if
    import ksa4_ctrl_pkg::*;
#(
    parameter int W = 4 * SLICE_W
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_cout;

    modport master (
        output in_valid, in_a, in_b, in_cin, out_ready,
        input  in_ready, out_valid, out_sum, out_cout
    );

    modport slave (
        input  in_valid, in_a, in_b, in_cin, out_ready,
        output in_ready, out_valid, out_sum, out_cout
    );
endinterface

// File: rtl/ksa4_lat_timer.sv
// Loadable down-counter: 'sample' is high for one cycle ADDER_LAT cycles after 'load'.
module ksa4_lat_timer
    import ksa4_ctrl_pkg::*;
#(
    parameter int ADDER_LAT = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic sample
);
    logic [LAT_CNT_W-1:0] cnt_q, cnt_d;
    logic                 armed_q, armed_d;

    // Terminal count reached while armed
    assign sample = armed_q && (cnt_q == '0);

    // Next count: reload on load, count down while armed, disarm at terminal count
    always_comb begin
        cnt_d   = cnt_q;
        armed_d = armed_q;
        if (load) begin
            cnt_d   = LAT_CNT_W'(ADDER_LAT - 1);
            armed_d = 1'b1;
        end else if (armed_q) begin
            if (cnt_q == '0) begin
                armed_d = 1'b0;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    // Counter registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            armed_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            armed_q <= armed_d;
        end
    end
endmodule

// File: rtl/ksa4_seq.sv
// Drives a W-bit add through an external pipelined 4-bit adder one slice at a time.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | ready for operands
//   ISSUE | slice k operands and carry driven to the adder (one cycle)
//   WAIT  | waiting ADDER_LAT cycles for the slice result
//   DONE  | full result presented until out_ready
module ksa4_seq
    import ksa4_ctrl_pkg::*;
#(
    parameter int NSLICE    = 4,
    parameter int ADDER_LAT = 2
) (
    input  logic               GCLK_Pad,
    input  logic               rst_Pad,
    ksa4_seq_if.slave          bus,
    output logic               busy,
    output logic [SLICE_W-1:0] add_a,
    output logic [SLICE_W-1:0] add_b,
    output logic               add_cin,
    input  logic [SLICE_W-1:0] add_sum,
    input  logic               add_cout
);
    localparam int W  = SLICE_W * NSLICE;
    localparam int KW = idx_w(NSLICE);

    state_e             state_q, state_d;
    logic [KW-1:0]      k_q, k_d;
    logic [W-1:0]       a_q, a_d, b_q, b_d, res_q, res_d;
    logic               carry_q, carry_d;
    logic [SLICE_W-1:0] add_a_q, add_a_d, add_b_q, add_b_d;
    logic               add_cin_q, add_cin_d;
    logic               sample;

    ksa4_lat_timer #(.ADDER_LAT(ADDER_LAT)) u_timer (
        .clk    (GCLK_Pad),
        .rst    (rst_Pad),
        .load   (state_q == ISSUE),
        .sample (sample)
    );

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.out_sum   = res_q;
    assign bus.out_cout  = carry_q;
    assign busy          = (state_q != IDLE);
    assign add_a         = add_a_q;
    assign add_b         = add_b_q;
    assign add_cin       = add_cin_q;

    // Next state; adder drive is computed on entry to ISSUE so it is high only during ISSUE
    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        a_d       = a_q;
        b_d       = b_q;
        res_d     = res_q;
        carry_d   = carry_q;
        add_a_d   = '0;
        add_b_d   = '0;
        add_cin_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d       = bus.in_a;
                    b_d       = bus.in_b;
                    carry_d   = bus.in_cin;
                    k_d       = '0;
                    res_d     = '0;
                    add_a_d   = bus.in_a[SLICE_W-1:0];
                    add_b_d   = bus.in_b[SLICE_W-1:0];
                    add_cin_d = bus.in_cin;
                    state_d   = ISSUE;
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (sample) begin
                    res_d[int'(k_q)*SLICE_W +: SLICE_W] = add_sum;
                    carry_d = add_cout;
                    if (int'(k_q) < NSLICE - 1) begin
                        k_d       = k_q + 1'b1;
                        add_a_d   = a_q[(int'(k_q) + 1)*SLICE_W +: SLICE_W];
                        add_b_d   = b_q[(int'(k_q) + 1)*SLICE_W +: SLICE_W];
                        add_cin_d = add_cout;
                        state_d   = ISSUE;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge GCLK_Pad) begin
        if (rst_Pad) begin
            state_q   <= IDLE;
            k_q       <= '0;
            a_q       <= '0;
            b_q       <= '0;
            res_q     <= '0;
            carry_q   <= 1'b0;
            add_a_q   <= '0;
            add_b_q   <= '0;
            add_cin_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            a_q       <= a_d;
            b_q       <= b_d;
            res_q     <= res_d;
            carry_q   <= carry_d;
            add_a_q   <= add_a_d;
            add_b_q   <= add_b_d;
            add_cin_q <= add_cin_d;
        end
    end
endmodule
